// File: rtl/turn_arbiter.sv
// turn_arbiter: shares the board move port between Player 1 (local) and
// Player 2 (SPI). Only the current player's move is considered; it is screened
// against the full-column mask and issued to the board with a req/ack handshake.
// Optional feature: define TURN_TIMEOUT_EN to auto-play the lowest free column
// when a player stalls for TIMEOUT_CYCLES cycles in WAIT_MOVE.
module turn_arbiter #(
  parameter int unsigned NUM_COLS       = 7,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          p1_col,
  input  logic                p1_valid,
  input  logic [2:0]          p2_col,
  input  logic                p2_valid,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_over,
  input  logic                board_ack,
  output logic                move_req,
  output logic [2:0]          move_col,
  output logic                move_player,
  output logic                turn,
  output logic                reject,
  output logic                timeout,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StWaitMove, StIssue, StOver} state_e;

  state_e     state_q, state_d;
  logic       turn_q, turn_d;
  logic [2:0] move_col_q, move_col_d;
  logic       move_player_q, move_player_d;
  logic       reject_q, reject_d;
  logic       timeout_q, timeout_d;

  logic       cand_valid;
  logic [2:0] cand_col;
  logic       cand_legal;

  logic       expired;
  logic       auto_found;
  logic [2:0] auto_col;

  // Select the on-turn player's move and check it against the full mask.
  always_comb begin
    cand_valid = turn_q ? p2_valid : p1_valid;
    cand_col   = turn_q ? p2_col : p1_col;
    cand_legal = 1'b0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (cand_col == 3'(i)) cand_legal = ~col_full[i];
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] tmr_q, tmr_d;

  // Lowest-index non-full column for the auto-play.
  always_comb begin
    auto_found = 1'b0;
    auto_col   = 3'd0;
    for (int i = int'(NUM_COLS) - 1; i >= 0; i--) begin
      if (!col_full[i]) begin
        auto_found = 1'b1;
        auto_col   = 3'(i);
      end
    end
  end

  // Turn timer: counts only in WAIT_MOVE, so it restarts from 0 on every entry.
  always_comb begin
    tmr_d = '0;
    if (state_q == StWaitMove && !reject_d) tmr_d = tmr_q + 1'b1;
  end

  // Turn timer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmr_q <= '0;
    else      tmr_q <= tmr_d;
  end

  assign expired = (tmr_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign expired               = 1'b0;
  assign auto_found            = 1'b0;
  assign auto_col              = 3'd0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    turn_d        = turn_q;
    move_col_d    = move_col_q;
    move_player_d = move_player_q;
    reject_d      = 1'b0;
    timeout_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          turn_d  = 1'b0;
          state_d = StWaitMove;
        end
      end
      StWaitMove: begin
        if (game_over) begin
          state_d = StOver;
        end else if (cand_valid && cand_legal) begin
          move_col_d    = cand_col;
          move_player_d = turn_q;
          state_d       = StIssue;
        end else begin
          reject_d = cand_valid;
          if (expired) begin
            if (auto_found) begin
              move_col_d    = auto_col;
              move_player_d = turn_q;
              timeout_d     = 1'b1;
              state_d       = StIssue;
            end else begin
              state_d = StOver;
            end
          end
        end
      end
      StIssue: begin
        if (board_ack) begin
          turn_d  = ~turn_q;
          state_d = StWaitMove;
        end
      end
      StOver: begin
        if (start) begin
          turn_d  = 1'b0;
          state_d = StWaitMove;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      turn_q        <= 1'b0;
      move_col_q    <= 3'd0;
      move_player_q <= 1'b0;
      reject_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      move_col_q    <= move_col_d;
      move_player_q <= move_player_d;
      reject_q      <= reject_d;
      timeout_q     <= timeout_d;
    end
  end

  // Request is decoded from state so reset drops it asynchronously.
  assign move_req    = (state_q == StIssue);
  assign busy        = (state_q == StWaitMove) || (state_q == StIssue);
  assign move_col    = move_col_q;
  assign move_player = move_player_q;
  assign turn        = turn_q;
  assign reject      = reject_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed self-checking bench for turn_arbiter.
module tb_turn_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] p1_col;
  logic       p1_valid;
  logic [2:0] p2_col;
  logic       p2_valid;
  logic [6:0] col_full;
  logic       game_over;
  logic       board_ack;
  logic       move_req;
  logic [2:0] move_col;
  logic       move_player;
  logic       turn;
  logic       reject;
  logic       timeout;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  turn_arbiter #(
    .NUM_COLS      (7),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .p1_col     (p1_col),
    .p1_valid   (p1_valid),
    .p2_col     (p2_col),
    .p2_valid   (p2_valid),
    .col_full   (col_full),
    .game_over  (game_over),
    .board_ack  (board_ack),
    .move_req   (move_req),
    .move_col   (move_col),
    .move_player(move_player),
    .turn       (turn),
    .reject     (reject),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    p1_col    = 3'd0;
    p1_valid  = 1'b0;
    p2_col    = 3'd0;
    p2_valid  = 1'b0;
    col_full  = 7'd0;
    game_over = 1'b0;
    board_ack = 1'b0;
    tick();
    tick();
    chk("rst_move_req", 32'(move_req), 0);
    chk("rst_move_col", 32'(move_col), 0);
    chk("rst_move_player", 32'(move_player), 0);
    chk("rst_turn", 32'(turn), 0);
    chk("rst_reject", 32'(reject), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;

    // Inputs other than start are ignored in IDLE.
    p1_valid = 1'b1; p1_col = 3'd1;
    tick();
    p1_valid = 1'b0;
    chk("idle_ignore_req", 32'(move_req), 0);
    chk("idle_ignore_busy", 32'(busy), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_turn", 32'(turn), 0);

    // P1 plays column 3.
    p1_valid = 1'b1; p1_col = 3'd3;
    tick();
    p1_valid = 1'b0;
    chk("p1_req", 32'(move_req), 1);
    chk("p1_col", 32'(move_col), 3);
    chk("p1_player", 32'(move_player), 0);
    // Pulses during ISSUE are ignored; request is held.
    p1_valid = 1'b1; p1_col = 3'd5;
    tick();
    p1_valid = 1'b0;
    chk("p1_hold_req", 32'(move_req), 1);
    chk("p1_hold_col", 32'(move_col), 3);
    board_ack = 1'b1;
    tick();
    board_ack = 1'b0;
    chk("ack1_req", 32'(move_req), 0);
    chk("ack1_turn", 32'(turn), 1);

    // Off-turn P1 dropped silently; P2 plays column 5.
    p1_valid = 1'b1; p1_col = 3'd2;
    tick();
    p1_valid = 1'b0;
    chk("offturn_req", 32'(move_req), 0);
    chk("offturn_reject", 32'(reject), 0);
    p2_valid = 1'b1; p2_col = 3'd5;
    tick();
    p2_valid = 1'b0;
    chk("p2_req", 32'(move_req), 1);
    chk("p2_col", 32'(move_col), 5);
    chk("p2_player", 32'(move_player), 1);
    board_ack = 1'b1;
    tick();
    board_ack = 1'b0;
    chk("ack2_turn", 32'(turn), 0);

    // Illegal moves: full column 2, then out-of-range column 7.
    col_full = 7'b0000100;
    p1_valid = 1'b1; p1_col = 3'd2;
    tick();
    p1_valid = 1'b0;
    chk("full_reject", 32'(reject), 1);
    chk("full_req", 32'(move_req), 0);
    tick();
    chk("reject_width", 32'(reject), 0);
    p1_valid = 1'b1; p1_col = 3'd7;
    tick();
    p1_valid = 1'b0;
    chk("range_reject", 32'(reject), 1);
    chk("range_req", 32'(move_req), 0);
    chk("range_busy", 32'(busy), 1);
    col_full = 7'd0;

    // Reset mid-handshake drops the request asynchronously.
    p1_valid = 1'b1; p1_col = 3'd1;
    tick();
    p1_valid = 1'b0;
    chk("pre_rst_req", 32'(move_req), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_req", 32'(move_req), 0);
    #1;
    rst = 1'b1;
    board_ack = 1'b1;
    tick();
    board_ack = 1'b0;
    chk("late_ack_req", 32'(move_req), 0);
    chk("late_ack_busy", 32'(busy), 0);
    chk("late_ack_turn", 32'(turn), 0);

    // game_over beats a legal move on the same cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    game_over = 1'b1; p1_valid = 1'b1; p1_col = 3'd4;
    tick();
    game_over = 1'b0; p1_valid = 1'b0;
    chk("over_req", 32'(move_req), 0);
    chk("over_busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 1);
    chk("restart_turn", 32'(turn), 0);
    p1_valid = 1'b1; p1_col = 3'd6;
    tick();
    p1_valid = 1'b0;
    chk("restart_col", 32'(move_col), 6);
    board_ack = 1'b1;
    tick();
    board_ack = 1'b0;
    chk("restart_turn_flip", 32'(turn), 1);

    // Stalled turn: auto-play after 16 cycles, or wait forever without the feature.
    col_full = 7'b0000011;
    for (int i = 0; i < 15; i++) tick();
    chk("pre_expiry_timeout", 32'(timeout), 0);
    chk("pre_expiry_req", 32'(move_req), 0);
    tick();
`ifdef TURN_TIMEOUT_EN
    chk("expiry_timeout", 32'(timeout), 1);
    chk("expiry_req", 32'(move_req), 1);
    chk("expiry_col", 32'(move_col), 2);
    chk("expiry_player", 32'(move_player), 1);
    tick();
    chk("timeout_width", 32'(timeout), 0);
`else
    for (int i = 0; i < 8; i++) tick();
    chk("no_timeout", 32'(timeout), 0);
    chk("no_auto_req", 32'(move_req), 0);
    chk("still_waiting", 32'(busy), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
